// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM state
// encoding, the default event header base, and the index-width helper.
package uart_arb_pkg;

  localparam logic [7:0] EVT_HDR_BASE_DEF = 8'hE0;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    REG_WAIT      = 3'd1,
    EVT_HDR       = 3'd2,
    EVT_HDR_WAIT  = 3'd3,
    EVT_DATA      = 3'd4,
    EVT_DATA_WAIT = 3'd5
  } state_t;

  // Width of a source index; a single source still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first asserted request at or after ptr,
// wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  // Scan from farthest to nearest so the request closest to ptr wins.
  always_comb begin
    logic [IW:0] j;
    // NOTE: every output gets a default before the loop so no path leaves
    // one unassigned, which would otherwise infer a latch.
    grant = '0;
    index = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IW + 1)'(k);
      if (j >= (IW + 1)'(N)) j = j - (IW + 1)'(N);
      if (req[j[IW-1:0]]) begin
        grant             = '0;
        grant[j[IW-1:0]]  = 1'b1;
        index             = j[IW-1:0];
        valid             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the regmap byte interface (strict
// priority) and NUM_EVT event sources. An event is sent as a header byte
// (EVT_HDR_BASE | index) followed by its payload, back-to-back.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NUM_EVT      = 2,
  parameter logic [7:0]  EVT_HDR_BASE = EVT_HDR_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 regmap_tx_trig,
  input  logic [7:0]           regmap_tx_data,
  input  logic                 regmap_busy,
  output logic                 arb_bsy,
  input  logic [NUM_EVT-1:0]   evt_req,
  input  logic [NUM_EVT*8-1:0] evt_data,
  output logic [NUM_EVT-1:0]   evt_ack,
  input  logic                 tx_bsy,
  output logic                 tx_trig,
  output logic [7:0]           tx_data,
  output logic                 ovf_err
);

  localparam int             IW       = idx_w(NUM_EVT);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_EVT - 1);

  state_t          state;
  logic            guard;     // first cycle of a *_WAIT state: UART may not yet show busy
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   cur_idx;   // source being served, for the header byte
  logic [7:0]      payload;

  logic [NUM_EVT-1:0] arb_grant;
  logic [IW-1:0]      arb_index;
  logic               arb_valid;
  logic [7:0]         evt_bytes [NUM_EVT];

  logic reg_accept;
  logic evt_grant;
  logic wait_done;

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_unpack
    assign evt_bytes[i] = evt_data[8*i +: 8];
  end

  rr_arbiter #(.N(NUM_EVT)) u_rr (
    .req   (evt_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .index (arb_index),
    .valid (arb_valid)
  );

  assign arb_bsy    = (state != IDLE) | tx_bsy;
  assign reg_accept = (state == IDLE) & regmap_tx_trig & ~tx_bsy;
  assign evt_grant  = (state == IDLE) & ~regmap_tx_trig & ~regmap_busy & ~tx_bsy & arb_valid;
  assign wait_done  = ~guard & ~tx_bsy;

  // Arbitration FSM, byte launch, ack pulses and sticky overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state   <= IDLE;
      guard   <= 1'b0;
      tx_trig <= 1'b0;
      tx_data <= '0;
      evt_ack <= '0;
      ovf_err <= 1'b0;
      rr_ptr  <= '0;
      cur_idx <= '0;
      payload <= '0;
    end else begin
      tx_trig <= 1'b0;
      evt_ack <= '0;
      guard   <= 1'b0;
      if (regmap_tx_trig && !reg_accept) ovf_err <= 1'b1;

      case (state)
        IDLE: begin
          if (reg_accept) begin
            tx_data <= regmap_tx_data;
            tx_trig <= 1'b1;
            guard   <= 1'b1;
            state   <= REG_WAIT;
          end else if (evt_grant) begin
            payload <= evt_bytes[arb_index];
            evt_ack <= arb_grant;
            cur_idx <= arb_index;
            rr_ptr  <= (arb_index == LAST_IDX) ? '0 : arb_index + IW'(1);
            state   <= EVT_HDR;
          end
        end
        REG_WAIT: begin
          if (wait_done) state <= IDLE;
        end
        EVT_HDR: begin
          tx_data <= EVT_HDR_BASE | 8'(cur_idx);
          tx_trig <= 1'b1;
          guard   <= 1'b1;
          state   <= EVT_HDR_WAIT;
        end
        EVT_HDR_WAIT: begin
          if (wait_done) state <= EVT_DATA;
        end
        EVT_DATA: begin
          tx_data <= payload;
          tx_trig <= 1'b1;
          guard   <= 1'b1;
          state   <= EVT_DATA_WAIT;
        end
        EVT_DATA_WAIT: begin
          if (wait_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a table of directed transactions, hand
// sequences for overflow / blocking / withdrawal / mid-frame reset, then a
// randomized run checked against a byte-stream reference model.
module tb_uart_tx_arbiter;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           regmap_tx_trig = 1'b0;
  logic [7:0]     regmap_tx_data = '0;
  logic           regmap_busy = 1'b0;
  logic           arb_bsy;
  logic [N-1:0]   evt_req = '0;
  logic [N*8-1:0] evt_data = '0;
  logic [N-1:0]   evt_ack;
  logic           tx_bsy = 1'b0;
  logic           tx_trig;
  logic [7:0]     tx_data;
  logic           ovf_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_EVT(N), .EVT_HDR_BASE(8'hE0)) dut (
    .clk            (clk),
    .rst            (rst),
    .regmap_tx_trig (regmap_tx_trig),
    .regmap_tx_data (regmap_tx_data),
    .regmap_busy    (regmap_busy),
    .arb_bsy        (arb_bsy),
    .evt_req        (evt_req),
    .evt_data       (evt_data),
    .evt_ack        (evt_ack),
    .tx_bsy         (tx_bsy),
    .tx_trig        (tx_trig),
    .tx_data        (tx_data),
    .ovf_err        (ovf_err)
  );

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         bsy_cnt   = 0;
  logic       prev_trig = 1'b0;
  logic [7:0] hold_byte = '0;
  int         m_ptr     = 0;
  bit         model_on  = 1'b0;

  typedef struct {
    logic        reg_trig;
    logic [7:0]  reg_data;
    logic [1:0]  req;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          first_ack;
    int          n;
    logic [31:0] bytes;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: at the falling edge run the UART model and the event sources,
  // then let combinational outputs settle.
  task automatic tick();
    int e;
    logic [7:0] b;
    @(negedge clk);
    if (rst) begin
      bsy_cnt   = 0;
      tx_bsy    = 1'b0;
      prev_trig = 1'b0;
    end else begin
      if (tx_trig) begin
        check("tx_trig_back_to_back", prev_trig, 0);
        check("tx_trig_while_uart_busy", (bsy_cnt != 0), 0);
        got_q.push_back(tx_data);
        hold_byte = tx_data;
        bsy_cnt   = $urandom_range(1, 4);
        tx_bsy    = 1'b1;
      end else if (bsy_cnt > 0) begin
        check("tx_data_stable", tx_data, hold_byte);
        bsy_cnt--;
        if (bsy_cnt == 0) tx_bsy = 1'b0;
      end
      prev_trig = tx_trig;
    end
    if (evt_ack != '0) begin
      if (model_on) begin
        e = -1;
        for (int k = 0; k < N; k++)
          if (e < 0 && evt_req[(m_ptr + k) % N]) e = (m_ptr + k) % N;
        check("ack_round_robin", evt_ack, (e < 0) ? 0 : (1 << e));
        check("grant_while_regmap_busy", regmap_busy, 0);
        if (e >= 0) begin
          b = 8'hE0 | 8'(e);
          exp_q.push_back(b);
          exp_q.push_back(evt_data[8*e +: 8]);
          m_ptr = (e + 1) % N;
        end
      end
      evt_req = evt_req & ~evt_ack;
    end
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (evt_req == '0 && !arb_bsy && !regmap_tx_trig) done = 1'b1;
      else begin
        check("arb_bsy_covers_tx_bsy", (arb_bsy || !tx_bsy), 1);
        tick();
      end
    end
    check({name, "_timeout"}, done, 1);
  endtask

  task automatic compare_stream(input string name, input int n, input logic [31:0] b);
    check({name, "_byte_count"}, got_q.size(), n);
    for (int k = 0; k < n && k < got_q.size(); k++)
      check({name, "_byte"}, got_q[k], b[31 - 8*k -: 8]);
    got_q.delete();
  endtask

  initial begin
    bit seen;
    //            trig  rdata  req    d0     d1     ack n  bytes
    vt[0] = '{1'b1, 8'h5A, 2'b00, 8'h00, 8'h00, -1, 1, 32'h5A000000};
    vt[1] = '{1'b0, 8'h00, 2'b10, 8'h00, 8'h3C,  1, 2, 32'hE13C0000};
    vt[2] = '{1'b0, 8'h00, 2'b11, 8'h11, 8'h22,  0, 4, 32'hE011E122};
    vt[3] = '{1'b0, 8'h00, 2'b11, 8'h44, 8'h55,  0, 4, 32'hE044E155};
    vt[4] = '{1'b1, 8'hA5, 2'b01, 8'h66, 8'h00, -1, 3, 32'hA5E06600};
    vt[5] = '{1'b0, 8'h00, 2'b01, 8'h00, 8'h00,  0, 2, 32'hE0000000};
    vt[6] = '{1'b0, 8'h00, 2'b10, 8'h00, 8'hFF,  1, 2, 32'hE1FF0000};

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check("rst_tx_trig", tx_trig, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_evt_ack", evt_ack, 0);
    check("rst_ovf_err", ovf_err, 0);
    check("rst_arb_bsy", arb_bsy, 0);
    rst = 1'b0;
    tick();

    // Directed transaction table.
    for (int i = 0; i < 7; i++) begin
      regmap_tx_trig = vt[i].reg_trig;
      regmap_tx_data = vt[i].reg_data;
      evt_data       = {vt[i].d1, vt[i].d0};
      evt_req        = vt[i].req;
      tick();
      check("arb_bsy_after_grant", arb_bsy, 1);
      if (vt[i].reg_trig) begin
        check("reg_trig_latency", tx_trig, 1);
        check("reg_tx_data", tx_data, vt[i].reg_data);
        check("reg_priority_no_ack", evt_ack, 0);
        regmap_tx_trig = 1'b0;
      end else begin
        check("evt_first_ack", evt_ack, 1 << vt[i].first_ack);
        tick();
        check("evt_hdr_latency", tx_trig, 1);
        check("evt_hdr_byte", tx_data, 8'hE0 | vt[i].first_ack);
      end
      wait_idle("vec");
      compare_stream("vec", vt[i].n, vt[i].bytes);
      check("vec_ovf_clear", ovf_err, 0);
    end

    // Request withdrawn before it could be granted.
    regmap_busy = 1'b1;
    evt_data    = 16'h0081;
    evt_req     = 2'b01;
    repeat (3) tick();
    evt_req     = 2'b00;
    regmap_busy = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (evt_ack != '0) seen = 1'b1;
    end
    check("withdrawn_no_ack", seen, 0);
    check("withdrawn_no_traffic", got_q.size(), 0);

    // Regmap trigger during EVT_HDR_WAIT is dropped and flagged.
    evt_data = 16'h0099;
    evt_req  = 2'b01;
    tick();
    tick();
    check("ovf_hdr_sent", tx_trig, 1);
    regmap_tx_trig = 1'b1;
    regmap_tx_data = 8'hC3;
    tick();
    regmap_tx_trig = 1'b0;
    check("ovf_set", ovf_err, 1);
    wait_idle("ovf");
    compare_stream("ovf", 2, 32'hE0990000);

    // Events are held off while a regmap read is in progress.
    regmap_busy = 1'b1;
    evt_data    = 16'h4B00;
    evt_req     = 2'b10;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (evt_ack != '0) seen = 1'b1;
    end
    check("blocked_no_ack", seen, 0);
    regmap_busy = 1'b0;
    tick();
    check("ack_after_busy_release", evt_ack, 2'b10);
    wait_idle("blocked");
    compare_stream("blocked", 2, 32'hE14B0000);
    check("ovf_sticky", ovf_err, 1);

    // Reset in EVT_DATA_WAIT aborts the frame.
    evt_data = 16'h0077;
    evt_req  = 2'b01;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (got_q.size() == 2) seen = 1'b1;
    end
    check("midframe_payload_reached", seen, 1);
    rst = 1'b1;
    tick();
    check("midrst_tx_trig", tx_trig, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_evt_ack", evt_ack, 0);
    check("midrst_ovf_err", ovf_err, 0);
    check("midrst_arb_bsy", arb_bsy, 0);
    rst = 1'b0;
    repeat (20) tick();
    compare_stream("midrst", 2, 32'hE0770000);

    // Randomized traffic against the byte-stream model.
    model_on = 1'b1;
    m_ptr    = 0;
    got_q.delete();
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      regmap_tx_trig = 1'b0;
      if ($urandom_range(0, 7) == 0) regmap_busy = ~regmap_busy;
      for (int i = 0; i < N; i++) begin
        if (!evt_req[i] && $urandom_range(0, 3) == 0) begin
          evt_data[8*i +: 8] = 8'($urandom);
          evt_req[i] = 1'b1;
        end
      end
      if (!arb_bsy && $urandom_range(0, 5) == 0) begin
        regmap_tx_data = 8'($urandom);
        regmap_tx_trig = 1'b1;
        exp_q.push_back(regmap_tx_data);
      end
      tick();
    end
    regmap_tx_trig = 1'b0;
    regmap_busy    = 1'b0;
    tick();
    wait_idle("rand_drain");
    check("rand_byte_count", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      check("rand_byte", got_q[k], exp_q[k]);
    check("rand_ovf_clear", ovf_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_EVT, default 2, meaning the number of event requesters sharing the UART transmitter (range 1..8).
REQ-002 SHALL have parameter EVT_HDR_BASE, default 8'hE0, meaning the header byte base; header sent = EVT_HDR_BASE | index.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 regmap_tx_trig  input  1  one-cycle request from regmap byte interface to send regmap_tx_data.
REQ-006 regmap_tx_data  input  8  read data or slave_id byte from regmap side.
REQ-007 regmap_busy  input  1  regmap read transaction in progress (its read_enable).
REQ-008 arb_bsy  output  1  busy indication returned to regmap interface as its tx_bsy.
REQ-009 evt_req  input  NUM_EVT  level request per event source; held until acked.
REQ-010 evt_data  input  NUM_EVT*8  payload byte per source; source i uses bits [8i+7:8i].
REQ-011 evt_ack  output  NUM_EVT  one-cycle pulse when source payload is latched.
REQ-012 tx_bsy  input  1  UART transmitter busy.
REQ-013 tx_trig  output  1  one-cycle start pulse to UART transmitter.
REQ-014 tx_data  output  8  byte to UART transmitter; stable from tx_trig until tx_bsy falls.
REQ-015 ovf_err  output  1  sticky flag: regmap_tx_trig arrived when it could not be accepted.

Function
REQ-016 SHALL implement FSM states IDLE, REG_WAIT, EVT_HDR, EVT_HDR_WAIT, EVT_DATA, EVT_DATA_WAIT.
REQ-017 arb_bsy SHALL equal (state != IDLE) | tx_bsy, combinationally.
REQ-018 In IDLE with regmap_tx_trig=1 and tx_bsy=0: latch regmap_tx_data into tx_data, assert tx_trig next cycle, go to REG_WAIT.
REQ-019 Regmap SHALL have strict priority: simultaneous regmap_tx_trig and evt_req in IDLE grants regmap; no evt_ack that cycle.
REQ-020 Event grant SHALL be blocked while regmap_busy=1 or tx_bsy=1.
REQ-021 In IDLE with no regmap trig, regmap_busy=0, tx_bsy=0, any evt_req: round-robin select index g starting from rr_ptr, latch evt_data[g] into payload register, pulse evt_ack[g], go to EVT_HDR.
REQ-022 rr_ptr SHALL reset to 0 and update to (g+1) mod NUM_EVT on each event grant.
REQ-023 EVT_HDR: drive tx_data=EVT_HDR_BASE|g, pulse tx_trig, go to EVT_HDR_WAIT.
REQ-024 Every *_WAIT state SHALL ignore tx_bsy on its first cycle (guard), then exit when tx_bsy=0.
REQ-025 EVT_HDR_WAIT exit -> EVT_DATA: tx_data=payload, pulse tx_trig, go to EVT_DATA_WAIT; EVT_DATA_WAIT exit -> IDLE.
REQ-026 REG_WAIT exit -> IDLE.
REQ-027 Header and payload of one event SHALL be sent back-to-back; regmap cannot interleave (arb_bsy high throughout).
REQ-028 regmap_tx_trig in any state other than IDLE, or in IDLE with tx_bsy=1, SHALL be dropped and set ovf_err; ovf_err clears only on rst.
REQ-029 tx_trig SHALL never be high on two consecutive cycles; at most one byte outstanding.
REQ-030 Latency: regmap_tx_trig to tx_trig = 1 cycle; evt grant to header tx_trig = 1 cycle.
REQ-031 evt_req deasserted before grant SHALL produce no ack and no traffic.

Reset
REQ-032 On rst: state=IDLE, tx_trig=0, tx_data=0, evt_ack=0, ovf_err=0, rr_ptr=0, payload=0.
REQ-033 rst mid-frame SHALL abort immediately; an event whose payload was acked is lost, no header/payload re-sent.

Structure
REQ-034 Package uart_arb_pkg SHALL hold the state enum typedef and default EVT_HDR_BASE constant.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, index, valid).

Verification
REQ-036 Regmap only: regmap_tx_trig with data 8'h5A, tx_bsy idle -> tx_trig next cycle, tx_data=8'h5A, arb_bsy high until tx_bsy falls.
REQ-037 Single event: evt_req[1]=1, evt_data[1]=8'h3C -> evt_ack[1] pulse, bytes 8'hE1 then 8'h3C, rr_ptr=0.
REQ-038 Fairness: evt_req=2'b11 held, both data 8'h11/8'h22 -> order E0,11,E1,22; re-request both -> next grant is source 0 again after source 1.
REQ-039 Collision: regmap_tx_trig and evt_req[0] same IDLE cycle -> regmap byte first, then E0+payload; ovf_err stays 0.
REQ-040 Overflow/block: regmap_tx_trig during EVT_HDR_WAIT -> dropped, ovf_err=1; evt_req while regmap_busy=1 -> no ack until regmap_busy=0.
REQ-041 Reset mid-frame: assert rst during EVT_DATA_WAIT -> next cycle IDLE, all outputs 0, no payload byte sent after rst.
